// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forward-select encodings and the hazard scoreboard entry.
package pipeline_pkg;

    // Register index width that scoreboard entries are built with.
    localparam int unsigned REG_IDX_W = 5;

    // Operand forward-select encodings driven to the EX operand muxes.
    localparam logic [1:0] FWD_REG      = 2'd0;
    localparam logic [1:0] FWD_EX_ALU   = 2'd1;
    localparam logic [1:0] FWD_MEM_ALU  = 2'd2;
    localparam logic [1:0] FWD_MEM_LOAD = 2'd3;

    // One in-flight producer: does it write, which register, and is it a load.
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest;
        logic                 is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-operand comparator: checks one ID source register against the EX and MEM producers.
// Register 0 and operands that are not read never match.
module hazard_match
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_IDX_W
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  uses_i,
    input  sb_entry_t             ex_e_i,
    input  sb_entry_t             mem_e_i,
    output logic                  match_ex_o,
    output logic                  match_mem_o,
    output logic                  mem_is_load_o
);

    logic src_live;

    // Match the source against each tracked producer.
    always_comb begin
        src_live      = uses_i & (src_i != '0);
        match_ex_o    = src_live & ex_e_i.valid & (ex_e_i.dest == src_i);
        match_mem_o   = src_live & mem_e_i.valid & (mem_e_i.dest == src_i);
        mem_is_load_o = mem_e_i.is_load;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside the ID stage: tracks EX/MEM destinations and drives ID stall,
// IF squash, redirect gating and per-operand forward selects.
// Optional macro HAZARD_PERF_COUNTERS_EN adds saturating stall/squash event counters.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter bit          DELAY_SLOT = 1'b1,
    parameter int unsigned REG_ADDR_W = REG_IDX_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  freeze,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_reads_in_id,
    input  logic                  id_writes_reg,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_is_load,
    input  logic                  id_redirect,
    output logic                  stall,
    output logic                  squash_if,
    output logic                  redirect_ok,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           squash_count
`endif
);

    sb_entry_t ex_e_q, ex_e_d, mem_e_q;
    logic      a_ex, a_mem, a_mem_ld;
    logic      b_ex, b_mem, b_mem_ld;
    logic      any_ex, any_mem;

    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs (
        .src_i        (id_rs),
        .uses_i       (id_uses_rs),
        .ex_e_i       (ex_e_q),
        .mem_e_i      (mem_e_q),
        .match_ex_o   (a_ex),
        .match_mem_o  (a_mem),
        .mem_is_load_o(a_mem_ld)
    );

    hazard_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rt (
        .src_i        (id_rt),
        .uses_i       (id_uses_rt),
        .ex_e_i       (ex_e_q),
        .mem_e_i      (mem_e_q),
        .match_ex_o   (b_ex),
        .match_mem_o  (b_mem),
        .mem_is_load_o(b_mem_ld)
    );

    // Stall, redirect gating, squash and forward selects from the held scoreboard state.
    always_comb begin
        any_ex  = a_ex | b_ex;
        any_mem = (a_mem & a_mem_ld) | (b_mem & b_mem_ld);
        stall   = id_valid & ((any_ex & ex_e_q.is_load)
                            | (id_reads_in_id & any_ex)
                            | (id_reads_in_id & any_mem));
        redirect_ok = id_redirect & ~stall;
        squash_if   = ~DELAY_SLOT & redirect_ok & ~freeze;

        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (!stall) begin
            if (a_ex)       fwd_a = FWD_EX_ALU;
            else if (a_mem) fwd_a = a_mem_ld ? FWD_MEM_LOAD : FWD_MEM_ALU;
            if (b_ex)       fwd_b = FWD_EX_ALU;
            else if (b_mem) fwd_b = b_mem_ld ? FWD_MEM_LOAD : FWD_MEM_ALU;
        end
    end

    // Next EX entry: only a real, issuing instruction that writes a non-zero register.
    always_comb begin
        ex_e_d = '0;
        if (id_valid && !stall && id_writes_reg && (id_dest != '0)) begin
            ex_e_d.valid   = 1'b1;
            ex_e_d.dest    = id_dest;
            ex_e_d.is_load = id_is_load;
        end
    end

    // Scoreboard shift; reset wins over freeze.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_e_q  <= '0;
            mem_e_q <= '0;
        end else if (!freeze) begin
            ex_e_q  <= ex_e_d;
            mem_e_q <= ex_e_q;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] squash_count_q, squash_count_d;

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        squash_count_d = squash_count_q;
        if (stall && !freeze && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (squash_if && (squash_count_q != 32'hFFFF_FFFF)) begin
            squash_count_d = squash_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= '0;
            squash_count_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            squash_count_q <= squash_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign squash_count = squash_count_q;
`endif

endmodule
